// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use hazard detector with multi-cycle stall hold and stall statistics
module hazard_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Rs_addr,
    input  logic [ADDR_W-1:0] Rt_addr,
    input  logic              Rs_used,
    input  logic              Rt_used,
    input  logic [ADDR_W-1:0] Rt_addr_IE,
    input  logic              MemRead_IE,
    input  logic              Flush,
    output logic              stall,
    output logic              IF_ID_Write,
    output logic              PCWrite,
    output logic [3:0]        stall_cnt,
    output logic [STAT_W-1:0] stall_total
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // The first bubble is issued combinationally from IDLE, so HOLD covers the rest.
    localparam logic [3:0] HOLD_INIT = 4'(LOAD_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt_nxt;
    logic        hit;

    assign hit = MemRead_IE && (Rt_addr_IE != '0) &&
                 ((Rs_used && (Rt_addr_IE == Rs_addr)) ||
                  (Rt_used && (Rt_addr_IE == Rt_addr)));

    // State and remaining-stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stall_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= cnt_nxt;
        end
    end

    // Next-state and stall decode; reset and flush both release the pipeline immediately.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = stall_cnt;
        stall     = 1'b0;
        if (rst) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
        end else if (Flush) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
        end else if (state == HOLD) begin
            stall = 1'b1;
            if (stall_cnt <= 4'd1) begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end else begin
                cnt_nxt = stall_cnt - 4'd1;
            end
        end else if (hit) begin
            stall = 1'b1;
            if (LOAD_LAT > 1) begin
                state_nxt = HOLD;
                cnt_nxt   = HOLD_INIT;
            end
        end
    end

    assign IF_ID_Write = !stall;
    assign PCWrite     = !stall;

    // Saturating count of cycles in which a bubble was inserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_total <= '0;
        end else if (stall && (stall_total != {STAT_W{1'b1}})) begin
            stall_total <= stall_total + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard at LOAD_LAT 1, 3 and 4
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_addr, rt_addr, rt_addr_ie;
    logic       rs_used, rt_used, mem_rd, flush;

    logic       stall_o [3];
    logic       ifw_o   [3];
    logic       pcw_o   [3];
    logic [3:0] cnt_o   [3];
    logic [3:0]  tot0;
    logic [15:0] tot1, tot2;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: per instance, bubbles still owed and stall cycles seen.
    int lat  [3] = '{1, 3, 4};
    int tmax [3] = '{15, 65535, 65535};
    int rem  [3];
    int cyc  [3];

    always #5 clk = ~clk;

    hazard_scoreboard #(.ADDR_W(5), .LOAD_LAT(1), .STAT_W(4)) u_lat1 (
        .clk(clk), .rst(rst), .Rs_addr(rs_addr), .Rt_addr(rt_addr), .Rs_used(rs_used),
        .Rt_used(rt_used), .Rt_addr_IE(rt_addr_ie), .MemRead_IE(mem_rd), .Flush(flush),
        .stall(stall_o[0]), .IF_ID_Write(ifw_o[0]), .PCWrite(pcw_o[0]),
        .stall_cnt(cnt_o[0]), .stall_total(tot0));

    hazard_scoreboard #(.ADDR_W(5), .LOAD_LAT(3), .STAT_W(16)) u_lat3 (
        .clk(clk), .rst(rst), .Rs_addr(rs_addr), .Rt_addr(rt_addr), .Rs_used(rs_used),
        .Rt_used(rt_used), .Rt_addr_IE(rt_addr_ie), .MemRead_IE(mem_rd), .Flush(flush),
        .stall(stall_o[1]), .IF_ID_Write(ifw_o[1]), .PCWrite(pcw_o[1]),
        .stall_cnt(cnt_o[1]), .stall_total(tot1));

    hazard_scoreboard #(.ADDR_W(5), .LOAD_LAT(4), .STAT_W(16)) u_lat4 (
        .clk(clk), .rst(rst), .Rs_addr(rs_addr), .Rt_addr(rt_addr), .Rs_used(rs_used),
        .Rt_used(rt_used), .Rt_addr_IE(rt_addr_ie), .MemRead_IE(mem_rd), .Flush(flush),
        .stall(stall_o[2]), .IF_ID_Write(ifw_o[2]), .PCWrite(pcw_o[2]),
        .stall_cnt(cnt_o[2]), .stall_total(tot2));

    function automatic int obs_tot(int k);
        if (k == 0) return int'(tot0);
        if (k == 1) return int'(tot1);
        return int'(tot2);
    endfunction

    function automatic logic model_hit();
        return mem_rd && (rt_addr_ie != 5'd0) &&
               ((rs_used && rt_addr_ie == rs_addr) || (rt_used && rt_addr_ie == rt_addr));
    endfunction

    function automatic logic exp_stall(int k);
        if (rst || flush) return 1'b0;
        if (rem[k] > 0) return 1'b1;
        return model_hit();
    endfunction

    task automatic tick();
        logic s [3];
        logic h;
        h = model_hit();
        for (int k = 0; k < 3; k++) s[k] = exp_stall(k);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                rem[k] = 0;
                cyc[k] = 0;
            end else begin
                if (s[k] && cyc[k] < tmax[k]) cyc[k] = cyc[k] + 1;
                if (flush) rem[k] = 0;
                else if (rem[k] > 0) rem[k] = rem[k] - 1;
                else if (h) rem[k] = lat[k] - 1;
            end
        end
        #1;
    endtask

    task automatic clear_in();
        rs_addr = 0; rt_addr = 0; rt_addr_ie = 0;
        rs_used = 0; rt_used = 0; mem_rd = 0; flush = 0;
    endtask

    task automatic set_hit();
        clear_in();
        mem_rd = 1; rt_addr_ie = 5'd5; rs_addr = 5'd5; rs_used = 1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        set_hit();
        rst = 1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (stall_o[k] !== 1'b0 || ifw_o[k] !== 1'b1 || pcw_o[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d]: stall=%b ifw=%b pcw=%b need 0/1/1", k, stall_o[k], ifw_o[k], pcw_o[k]);
            end
        end
        tick();
        rst = 0;
        clear_in();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (cnt_o[k] !== 4'd0 || obs_tot(k) != 0) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: cnt=%0d total=%0d need 0/0", k, cnt_o[k], obs_tot(k));
            end
        end
    endtask

    task automatic test_single_cycle();
        do_reset();
        set_hit();
        @(negedge clk);
        n_total++;
        if (stall_o[0] !== 1'b1 || ifw_o[0] !== 1'b0 || pcw_o[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL lat1_stall: stall=%b ifw=%b pcw=%b need 1/0/0", stall_o[0], ifw_o[0], pcw_o[0]);
        end
        tick();
        clear_in();
        @(negedge clk);
        n_total++;
        if (stall_o[0] !== 1'b0 || cnt_o[0] !== 4'd0 || tot0 !== 4'd1) begin
            n_bad++;
            $display("FAIL lat1_after: stall=%b cnt=%0d total=%0d need 0/0/1", stall_o[0], cnt_o[0], tot0);
        end
        tick();
    endtask

    task automatic test_multi_cycle();
        logic       es [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] ec [4] = '{4'd0, 4'd2, 4'd1, 4'd0};
        do_reset();
        set_hit();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (stall_o[1] !== es[i] || cnt_o[1] !== ec[i] || ifw_o[1] !== !es[i]) begin
                n_bad++;
                $display("FAIL lat3_seq[%0d]: stall=%b cnt=%0d ifw=%b need %b/%0d/%b",
                         i, stall_o[1], cnt_o[1], ifw_o[1], es[i], ec[i], !es[i]);
            end
            tick();
            clear_in();
        end
        n_total++;
        if (tot1 !== 16'd3) begin
            n_bad++;
            $display("FAIL lat3_total: got %0d need 3", tot1);
        end
    endtask

    task automatic test_no_hit();
        do_reset();
        clear_in();
        mem_rd = 1; rs_used = 1; rt_used = 1;
        @(negedge clk);
        n_total++;
        if (stall_o[0] !== 1'b0 || stall_o[1] !== 1'b0 || stall_o[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL no_hit_r0: stall=%b%b%b need 000", stall_o[0], stall_o[1], stall_o[2]);
        end
        tick();
        clear_in();
        mem_rd = 1; rt_addr_ie = 5'd7; rt_addr = 5'd7; rt_used = 0; rs_addr = 5'd3; rs_used = 1;
        @(negedge clk);
        n_total++;
        if (stall_o[0] !== 1'b0 || stall_o[1] !== 1'b0 || stall_o[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL no_hit_unused: stall=%b%b%b need 000", stall_o[0], stall_o[1], stall_o[2]);
        end
        tick();
        set_hit();
        mem_rd = 0;
        @(negedge clk);
        n_total++;
        if (stall_o[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL no_hit_noload: stall=%b need 0", stall_o[2]);
        end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        set_hit();
        tick();
        clear_in();
        tick();
        flush = 1;
        @(negedge clk);
        n_total++;
        if (stall_o[2] !== 1'b0 || ifw_o[2] !== 1'b1 || pcw_o[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_cycle: stall=%b ifw=%b pcw=%b need 0/1/1", stall_o[2], ifw_o[2], pcw_o[2]);
        end
        tick();
        flush = 0;
        @(negedge clk);
        n_total++;
        if (stall_o[2] !== 1'b0 || cnt_o[2] !== 4'd0 || tot2 !== 16'd2) begin
            n_bad++;
            $display("FAIL flush_after: stall=%b cnt=%0d total=%0d need 0/0/2", stall_o[2], cnt_o[2], tot2);
        end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        set_hit();
        tick();
        clear_in();
        tick();
        rst = 1;
        @(negedge clk);
        n_total++;
        if (stall_o[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_hold_now: stall=%b need 0", stall_o[2]);
        end
        tick();
        rst = 0;
        @(negedge clk);
        n_total++;
        if (stall_o[2] !== 1'b0 || cnt_o[2] !== 4'd0 || tot2 !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_hold_after: stall=%b cnt=%0d total=%0d need 0/0/0", stall_o[2], cnt_o[2], tot2);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_hit();
            tick();
            clear_in();
            tick();
            if (i == 13) begin
                @(negedge clk);
                n_total++;
                if (tot0 !== 4'd14) begin
                    n_bad++;
                    $display("FAIL sat_mid: total=%0d need 14", tot0);
                end
            end
        end
        @(negedge clk);
        n_total++;
        if (tot0 !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_final: total=%0d need 15", tot0);
        end
    endtask

    task automatic test_random();
        logic e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rs_addr    = 5'($urandom_range(0, 3));
            rt_addr    = 5'($urandom_range(0, 3));
            rt_addr_ie = 5'($urandom_range(0, 3));
            rs_used    = 1'($urandom_range(0, 1));
            rt_used    = 1'($urandom_range(0, 1));
            mem_rd     = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 9) == 0);
            rst        = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                e = exp_stall(k);
                n_total++;
                if (stall_o[k] !== e || ifw_o[k] !== !e || pcw_o[k] !== !e ||
                    cnt_o[k] !== 4'(rem[k]) || obs_tot(k) != cyc[k]) begin
                    n_bad++;
                    $display("FAIL random[%0d] dut%0d: stall=%b ifw=%b pcw=%b cnt=%0d total=%0d need stall=%b cnt=%0d total=%0d",
                             i, k, stall_o[k], ifw_o[k], pcw_o[k], cnt_o[k], obs_tot(k), e, rem[k], cyc[k]);
                end
            end
            tick();
        end
        rst = 0;
        clear_in();
    endtask

    initial begin
        rst = 1;
        clear_in();
        for (int k = 0; k < 3; k++) begin
            rem[k] = 0;
            cyc[k] = 0;
        end
        #1;
        test_reset();
        test_single_cycle();
        test_multi_cycle();
        test_no_hit();
        test_flush();
        test_reset_mid_hold();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
Parameters:
REQ-001 The block SHALL have parameter ADDR_W, default 5, register-address width.
REQ-002 The block SHALL have parameter LOAD_LAT, default 1, range 1..8, number of bubble cycles a load-use hazard requires.
REQ-003 The block SHALL have parameter STAT_W, default 16, width of the stall-cycle statistics counter.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port Rs_addr, input, ADDR_W bits, ID-stage first source register.
REQ-007 The block SHALL have port Rt_addr, input, ADDR_W bits, ID-stage second source register.
REQ-008 The block SHALL have ports Rs_used and Rt_used, input, 1 bit each, ID-stage instruction actually reads that source.
REQ-009 The block SHALL have port Rt_addr_IE, input, ADDR_W bits, destination of the instruction in EX.
REQ-010 The block SHALL have port MemRead_IE, input, 1 bit, EX instruction is a load.
REQ-011 The block SHALL have port Flush, input, 1 bit, branch/jump flush of IF/ID.
REQ-012 The block SHALL have port stall, output, 1 bit, insert bubble into ID/EX.
REQ-013 The block SHALL have ports IF_ID_Write and PCWrite, output, 1 bit each, active-high write enables.
REQ-014 The block SHALL have port stall_cnt, output, 4 bits, remaining registered stall cycles.
REQ-015 The block SHALL have port stall_total, output, STAT_W bits, saturating count of stall cycles.

Function
REQ-016 hit SHALL be MemRead_IE && (Rt_addr_IE != 0) && ((Rs_used && Rt_addr_IE == Rs_addr) || (Rt_used && Rt_addr_IE == Rt_addr)).
REQ-017 The FSM SHALL have two states: IDLE and HOLD.
REQ-018 In IDLE, when hit && !Flush, the block SHALL assert stall=1, IF_ID_Write=0, PCWrite=0 combinationally in the same cycle.
REQ-019 In IDLE with hit && !Flush, the next state SHALL be HOLD with stall_cnt loaded to LOAD_LAT-1 when LOAD_LAT>1, else IDLE.
REQ-020 In HOLD, the outputs SHALL be stall=1, IF_ID_Write=0, PCWrite=0, and hit SHALL be ignored.
REQ-021 In HOLD, stall_cnt SHALL decrement each cycle; when stall_cnt==1 the next state SHALL be IDLE with stall_cnt=0.
REQ-022 Total bubble cycles per hazard SHALL equal exactly LOAD_LAT.
REQ-023 When not stalling, the outputs SHALL be stall=0, IF_ID_Write=1, PCWrite=1.
REQ-024 Flush SHALL have priority in any state: outputs not stalled that cycle, next state IDLE, stall_cnt=0.
REQ-025 stall_total SHALL increment by 1 in every cycle stall=1 and hold at 2^STAT_W-1 (no wrap).
REQ-026 A new hit in the cycle HOLD exits SHALL NOT be evaluated; a hit is evaluated only in IDLE cycles.
REQ-027 With LOAD_LAT=1 and Flush=0, behaviour SHALL be purely combinational on hit, with no HOLD entry.

Reset
REQ-028 With rst=1 at a clock edge, the state SHALL become IDLE, stall_cnt=0, and stall_total=0.
REQ-029 While rst=1, the outputs SHALL be stall=0, IF_ID_Write=1, PCWrite=1, regardless of hit.
REQ-030 Reset asserted in HOLD SHALL abort the stall on the next edge; Flush and reset SHALL NOT increment stall_total.

Verification
REQ-031 The bench SHALL cover: LOAD_LAT=1, MemRead_IE=1, Rt_addr_IE=5, Rs_addr=5, Rs_used=1 -> stall=1 for 1 cycle, stall_total=1.
REQ-032 The bench SHALL cover: LOAD_LAT=3, same hit -> stall=1 for exactly 3 cycles with stall_cnt 0->2->1->0, then IF_ID_Write=1.
REQ-033 The bench SHALL cover: Rt_addr_IE=0 with matching sources, or Rt_used=0 with Rt match -> stall=0.
REQ-034 The bench SHALL cover: LOAD_LAT=4 hit, Flush=1 in the 2nd HOLD cycle -> stall=0 that cycle, IDLE next, stall_total=2.
REQ-035 The bench SHALL cover: rst=1 mid-HOLD -> next cycle stall=0, stall_cnt=0, stall_total=0.
REQ-036 The bench SHALL cover: STAT_W=4, 20 single-cycle hazards -> stall_total saturates at 15.
